delay_track_ctrl: RTL and testbench

DELAY_TRACK_CTRL -- requirements
Module: delay_track_ctrl

---
 rtl/delay_ctrl_pkg.sv | 24 ++
 rtl/len_slewer.sv | 48 ++++
 rtl/delay_track_ctrl.sv | 167 ++++++++++++++++
 tb/tb_delay_track_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the delay tracking controller: register offsets, state codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package delay_ctrl_pkg;

  // Register offsets relative to the settings-bus base address
  localparam logic [7:0] REG_CTRL        = 8'd0;
  localparam logic [7:0] REG_MANUAL_LEN  = 8'd1;
  localparam logic [7:0] REG_MAX_STEP    = 8'd2;
  localparam logic [7:0] REG_LOCK_THRESH = 8'd3;

  // Controller states (encoding is visible on state_o for debug)
  localparam logic [1:0] ST_MANUAL  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // CTRL register layout: bit1 = freeze, bit0 = track_en
  typedef struct packed {
    logic freeze;
    logic track_en;
  } ctrl_t;

endpackage

// File: rtl/len_slewer.sv
// Slew limiter: moves len toward target by at most max_step per eop, never past target.
// Latency: len_o updates on the clock edge that samples eop_i.
// Backpressure: none; every eop_i pulse is acted on.
// Ports: clk/reset (sync, active-high), eop_i strobe, target_i, max_step_i (0 acts as 1), len_o.
module len_slewer #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             eop_i,
  input  logic [LEN_W-1:0] target_i,
  input  logic [7:0]       max_step_i,
  output logic [LEN_W-1:0] len_o
);

  // Common width wide enough to compare a len difference against an 8-bit step
  localparam int DW = (LEN_W > 8) ? LEN_W : 8;

  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    step, diff, mv;

  always_comb begin
    step  = (max_step_i == 8'd0) ? DW'(1) : DW'(max_step_i);
    diff  = '0;
    mv    = '0;
    len_d = len_q;
    if (eop_i) begin
      // Clamping the move to the remaining distance prevents overshoot
      if (target_i > len_q) begin
        diff  = DW'(target_i - len_q);
        mv    = (diff < step) ? diff : step;
        len_d = len_q + mv[LEN_W-1:0];
      end else if (target_i < len_q) begin
        diff  = DW'(len_q - target_i);
        mv    = (diff < step) ? diff : step;
        len_d = len_q - mv[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) len_q <= '0;
    else       len_q <= len_d;
  end

  assign len_o = len_q;

endmodule

// File: rtl/delay_track_ctrl.sv
// Delay tracking controller: averages offset measurements into a len target, slews len on eop.
// Latency: target updates the cycle after the completing measurement; len moves the cycle after eop.
// Backpressure: none; every meas_valid/eop strobe is consumed (meas ignored in HOLD).
// Ports: clk, reset (sync high), clear, settings bus (set_stb/addr/data), meas_valid/meas_offset,
//        eop; outputs len, locked, state_o (all registered).
module delay_track_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int MAX_LEN_LOG2 = 10,
  parameter int AVG_LOG2     = 3,
  parameter int SR_BASE      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic                    meas_valid,
  input  logic [MAX_LEN_LOG2:0]   meas_offset,
  input  logic                    eop,
  output logic [MAX_LEN_LOG2-1:0] len,
  output logic                    locked,
  output logic [1:0]              state_o
);

  localparam int W     = MAX_LEN_LOG2;
  localparam int A     = AVG_LOG2;
  // 2^A samples of W+1-bit signed values fit exactly in W+1+A bits
  localparam int ACC_W = W + 1 + A;
  localparam int AVG_W = W + 1;
  localparam int CNT_W = A + 1;
  localparam int UW    = (W > 8) ? W : 8;

  localparam logic [7:0] ADDR_CTRL   = 8'(SR_BASE + int'(REG_CTRL));
  localparam logic [7:0] ADDR_MANUAL = 8'(SR_BASE + int'(REG_MANUAL_LEN));
  localparam logic [7:0] ADDR_STEP   = 8'(SR_BASE + int'(REG_MAX_STEP));
  localparam logic [7:0] ADDR_THRESH = 8'(SR_BASE + int'(REG_LOCK_THRESH));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** A) - 1);

  // Settings registers
  ctrl_t        ctrl_q;
  logic [W-1:0] manual_len_q;
  logic [7:0]   max_step_q;
  logic [W-1:0] lock_thresh_q;

  // Tracking state
  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]            target_q, target_d;
  logic                    locked_q, locked_d;

  logic [W-1:0]            len_w;
  logic signed [ACC_W-1:0] meas_ext, acc_sum;
  logic signed [AVG_W-1:0] avg;
  logic [AVG_W-1:0]        abs_avg;
  logic signed [W+1:0]     tgt_sum;
  logic [W-1:0]            tgt_sat;
  logic                    avg_in_lock;
  logic                    unused_set_data;

  assign unused_set_data = ^set_data[31:UW];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      manual_len_q  <= '0;
      max_step_q    <= 8'd1;
      lock_thresh_q <= '0;
    end else if (set_stb) begin
      if (set_addr == ADDR_CTRL)   ctrl_q        <= ctrl_t'(set_data[1:0]);
      if (set_addr == ADDR_MANUAL) manual_len_q  <= set_data[W-1:0];
      if (set_addr == ADDR_STEP)   max_step_q    <= set_data[7:0];
      if (set_addr == ADDR_THRESH) lock_thresh_q <= set_data[W-1:0];
    end
  end

  // Average including the current sample; only used when it completes the window
  always_comb begin
    meas_ext = ACC_W'(signed'(meas_offset));
    acc_sum  = acc_q + meas_ext;
    avg      = AVG_W'(acc_sum >>> A);
    abs_avg  = avg[AVG_W-1] ? AVG_W'(-avg) : AVG_W'(avg);
    avg_in_lock = (abs_avg <= {1'b0, lock_thresh_q});
    tgt_sum  = signed'({2'b00, len_w}) + (W+2)'(avg);
    if (tgt_sum[W+1])  tgt_sat = '0;
    else if (tgt_sum[W]) tgt_sat = '1;
    else               tgt_sat = tgt_sum[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    locked_d = locked_q;
    if (clear) begin
      acc_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
      target_d = len_w;
      state_d  = ctrl_q.track_en ? ST_ACQUIRE : ST_MANUAL;
    end else if (!ctrl_q.track_en) begin
      acc_d    = '0;
      cnt_d    = '0;
      locked_d = 1'b0;
      target_d = manual_len_q;
      state_d  = ST_MANUAL;
    end else begin
      case (state_q)
        ST_MANUAL: state_d = ST_ACQUIRE;
        ST_ACQUIRE, ST_TRACK: begin
          if (ctrl_q.freeze) begin
            state_d = ST_HOLD;
          end else if (meas_valid) begin
            if (cnt_q == CNT_LAST) begin
              acc_d    = '0;
              cnt_d    = '0;
              target_d = tgt_sat;
              // The first average out of ACQUIRE only moves the target
              if (state_q == ST_TRACK) locked_d = avg_in_lock;
              state_d  = ST_TRACK;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: if (!ctrl_q.freeze) state_d = ST_TRACK;
        default: state_d = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_MANUAL;
      acc_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      locked_q <= locked_d;
    end
  end

  // Slewer sees the registered target, so an average completing alongside an eop
  // only influences the following eop
  len_slewer #(.LEN_W(W)) u_len_slewer (
    .clk        (clk),
    .reset      (reset),
    .eop_i      (eop),
    .target_i   (target_q),
    .max_step_i (max_step_q),
    .len_o      (len_w)
  );

  assign len     = len_w;
  assign locked  = locked_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_delay_track_ctrl.sv
// Testbench for delay_track_ctrl: directed stimulus, expected outputs queued per eop/probe event.
// Latency: monitor compares on the falling edge after the event is sampled.
// Backpressure: n/a.
module tb_delay_track_ctrl;

  localparam int W = 10;
  localparam logic [7:0] A_CTRL = 8'd16, A_MAN = 8'd17, A_STEP = 8'd18, A_THR = 8'd19;
  localparam logic [1:0] MAN = 2'd0, ACQ = 2'd1, TRK = 2'd2, HLD = 2'd3;

  logic          clk, reset, clear, set_stb, meas_valid, eop, locked, probe;
  logic [7:0]    set_addr;
  logic [31:0]   set_data;
  logic [W:0]    meas_offset;
  logic [W-1:0]  len;
  logic [1:0]    state_o;

  typedef struct {
    logic [W-1:0] len;
    logic [1:0]   st;
    logic         lk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ev_q = 1'b0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  delay_track_ctrl #(.MAX_LEN_LOG2(W), .AVG_LOG2(3), .SR_BASE(16)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .meas_valid(meas_valid), .meas_offset(meas_offset), .eop(eop),
    .len(len), .locked(locked), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int req, input int idx);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s (event %0d): got %0d, expected %0d", nm, idx, act, req);
    end
  endfunction

  // Monitor: every eop/probe produces one registered observation to compare
  int evn = 0;
  always @(posedge clk) ev_q <= eop | probe;

  always @(negedge clk) begin
    exp_t e;
    if (ev_q) begin
      evn++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event (event %0d): got len %0d, expected no event", evn, len);
      end else begin
        e = exp_q.pop_front();
        chk("len",    int'(len),     int'(e.len), evn);
        chk("state",  int'(state_o), int'(e.st),  evn);
        chk("locked", int'(locked),  int'(e.lk),  evn);
      end
    end
    if (end_req && !end_done) begin
      chk("pending_expectations", exp_q.size(), 0, evn);
      end_done <= 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input int d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic measn(input int n, input int v);
    repeat (n) begin
      meas_valid = 1'b1; meas_offset = (W+1)'(v);
      tick();
      meas_valid = 1'b0;
    end
  endtask

  function automatic void push(input int l, input logic [1:0] s, input logic k);
    exp_t e;
    e.len = W'(l); e.st = s; e.lk = k;
    exp_q.push_back(e);
  endfunction

  task automatic do_eop(input int l, input logic [1:0] s, input logic k);
    push(l, s, k);
    eop = 1'b1; tick(); eop = 1'b0; tick();
  endtask

  task automatic do_probe(input int l, input logic [1:0] s, input logic k);
    push(l, s, k);
    probe = 1'b1; tick(); probe = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    meas_valid = 1'b0; meas_offset = '0; eop = 1'b0; probe = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    do_probe(0, MAN, 0);

    // Manual slew with unit step: 1..10, then held at 10
    wr(A_MAN, 10);
    for (int i = 1; i <= 12; i++) do_eop((i < 10) ? i : 10, MAN, 0);

    // Acquire: +4 average from len 10 -> target 14, step 2
    wr(A_STEP, 2);
    wr(A_CTRL, 1);
    do_probe(10, ACQ, 0);
    measn(8, 4);
    do_probe(10, TRK, 0);
    do_eop(12, TRK, 0);
    do_eop(14, TRK, 0);

    // Back to manual at len 2
    wr(A_MAN, 2);
    wr(A_CTRL, 0);
    for (int i = 0; i < 6; i++) do_eop(12 - 2 * i, MAN, 0);

    // Negative floor average and saturation at 0
    wr(A_CTRL, 1);
    measn(8, -5);
    do_probe(2, TRK, 0);
    do_eop(0, TRK, 0);
    do_eop(0, TRK, 0);
    measn(8, 10);
    for (int i = 1; i <= 5; i++) do_eop(2 * i, TRK, 0);
    // Sum -1 floors to -1: target 9, reached without overshoot
    measn(7, 0);
    measn(1, -1);
    do_eop(9, TRK, 0);

    // Lock threshold 1
    wr(A_THR, 1);
    measn(8, 1);
    do_probe(9, TRK, 1);
    do_eop(10, TRK, 1);
    measn(8, 3);
    do_eop(12, TRK, 0);
    do_eop(13, TRK, 0);

    // Freeze holds target and locked, measurements ignored
    measn(8, 0);
    do_probe(13, TRK, 1);
    wr(A_CTRL, 3);
    do_probe(13, HLD, 1);
    measn(20, 50);
    do_eop(13, HLD, 1);
    wr(A_CTRL, 1);
    do_probe(13, TRK, 1);
    measn(8, 2);
    do_eop(15, TRK, 0);

    // Clear discards partial window
    measn(5, 100);
    clear = 1'b1; tick(); clear = 1'b0; tick();
    do_probe(15, ACQ, 0);
    measn(8, -2);
    do_eop(13, TRK, 0);

    // Completing average and eop together: slew uses the old target
    measn(7, 4);
    push(13, TRK, 0);
    meas_valid = 1'b1; meas_offset = (W+1)'(4); eop = 1'b1;
    tick();
    meas_valid = 1'b0; eop = 1'b0;
    tick();
    do_eop(15, TRK, 0);
    do_eop(17, TRK, 0);

    // Reset mid-slew
    wr(A_MAN, 0);
    wr(A_CTRL, 0);
    do_eop(15, MAN, 0);
    push(0, MAN, 0);
    reset = 1'b1; eop = 1'b1;
    tick();
    eop = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // MAX_STEP of 0 acts as 1
    wr(A_STEP, 0);
    wr(A_MAN, 5);
    do_eop(1, MAN, 0);
    do_eop(2, MAN, 0);

    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_done; i++) tick();
    if (!end_done) begin
      errors++;
      $display("FAIL end_check_timeout: got no end check, expected one");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
